// File: rtl/ccx_cken_seq.sv
// Cluster clock-header sequencer: staggered cken power-up, reset/debug-init release, ordered power-down.
// Optional `CCX_CKEN_SCAN_OVR_EN forces cluster_cken to all ones while se=1.
module ccx_cken_seq #(
  parameter int NCLUST = 4,
  parameter int GAP_W  = 4,
  parameter int SETTLE = 8
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              start,
  input  logic              stop,
  input  logic              dbg_req,
  input  logic [GAP_W-1:0]  gap,
  input  logic              se,
  output logic [NCLUST-1:0] cluster_cken,
  output logic              cluster_grst_l,
  output logic              dbginit_l,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // IDLE    | all clocks off, waiting for start
  // ENABLE  | raising cken bits in ascending order, gap_q cycles apart
  // SETTLE  | all clocks on, waiting SETTLE cycles before reset release
  // RUN     | clusters out of reset
  // DBG     | debug-init held low for SETTLE cycles
  // DISABLE | clearing cken bits in descending order, gap_q cycles apart
  typedef enum logic [2:0] {
    IDLE, ENABLE, SETTLE_ST, RUN, DBG, DISABLE
  } state_t;

  localparam int IDX_W = $clog2(NCLUST);
  localparam int SET_W = $clog2(SETTLE);
  localparam int CNT_W = (GAP_W > SET_W) ? GAP_W : SET_W;
  localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_EN = IDX_W'(NCLUST - 2);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n, hi_idx;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gap_q, gap_q_n;
  logic [NCLUST-1:0]  cken_q, cken_n;
  logic               grst_q, grst_n;
  logic               dbg_q, dbg_n;
  logic               busy_n, done_n;
  logic               abort;

  // cken is always a contiguous run from bit 0, so the top set bit is the disable start point
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NCLUST; i++) begin
      if (cken_q[i]) hi_idx = IDX_W'(i);
    end
  end

  assign abort = stop && (state == ENABLE || state == SETTLE_ST ||
                          state == RUN || state == DBG);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    gap_q_n = gap_q;
    cken_n  = cken_q;
    grst_n  = grst_q;
    dbg_n   = dbg_q;
    done_n  = 1'b0;

    if (abort) begin
      grst_n  = 1'b0;
      dbg_n   = 1'b0;
      gap_q_n = gap;
      cnt_n   = CNT_W'(gap);
      idx_n   = hi_idx;
      cken_n  = cken_q >> 1;
      if (hi_idx == '0) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = DISABLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gap_q_n = gap;
            cnt_n   = CNT_W'(gap);
            idx_n   = '0;
            cken_n  = {{(NCLUST-1){1'b0}}, 1'b1};
            state_n = ENABLE;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            cken_n = {cken_q[NCLUST-2:0], 1'b1};
            idx_n  = idx + 1'b1;
            if (idx == IDX_LAST_EN) begin
              cnt_n   = SETTLE_LD;
              state_n = SETTLE_ST;
            end else begin
              cnt_n = CNT_W'(gap_q);
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        SETTLE_ST: begin
          if (cnt == '0) begin
            grst_n  = 1'b1;
            dbg_n   = 1'b1;
            done_n  = 1'b1;
            state_n = RUN;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        RUN: begin
          if (dbg_req) begin
            dbg_n   = 1'b0;
            cnt_n   = SETTLE_LD;
            state_n = DBG;
          end
        end
        DBG: begin
          if (cnt == '0) begin
            dbg_n   = 1'b1;
            done_n  = 1'b1;
            state_n = RUN;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        DISABLE: begin
          if (cnt == '0) begin
            cken_n = cken_q >> 1;
            idx_n  = idx - 1'b1;
            cnt_n  = CNT_W'(gap_q);
            if (idx == IDX_ONE) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy_n = (state_n == ENABLE) || (state_n == SETTLE_ST) ||
                  (state_n == DBG)    || (state_n == DISABLE);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      gap_q  <= '0;
      cken_q <= '0;
      grst_q <= 1'b0;
      dbg_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      gap_q  <= gap_q_n;
      cken_q <= cken_n;
      grst_q <= grst_n;
      dbg_q  <= dbg_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign cluster_grst_l = grst_q;
  assign dbginit_l      = dbg_q;

`ifdef CCX_CKEN_SCAN_OVR_EN
  // scan forces every header on without disturbing the sequencer state
  assign cluster_cken = se ? {NCLUST{1'b1}} : cken_q;
`else
  logic unused_se;
  assign unused_se    = se;
  assign cluster_cken = cken_q;
`endif

endmodule

// File: tb/tb_ccx_cken_seq.sv
// Directed bench for ccx_cken_seq: table of per-cycle vectors plus async-reset and scan sequences.
module tb_ccx_cken_seq;

  logic       rclk = 1'b0;
  logic       arst_l = 1'b1;
  logic       start = 1'b0, stop = 1'b0, dbg_req = 1'b0, se = 1'b0;
  logic [3:0] gap = 4'd0;
  logic [3:0] cluster_cken;
  logic       cluster_grst_l, dbginit_l, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  ccx_cken_seq #(.NCLUST(4), .GAP_W(4), .SETTLE(8)) dut (
    .rclk(rclk), .arst_l(arst_l), .start(start), .stop(stop), .dbg_req(dbg_req),
    .gap(gap), .se(se), .cluster_cken(cluster_cken), .cluster_grst_l(cluster_grst_l),
    .dbginit_l(dbginit_l), .busy(busy), .done(done)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic       st, sp, dq;
    logic [3:0] g;
    logic [3:0] ck;
    logic       gr, dl, bz, dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic st, logic sp, logic dq, logic [3:0] g,
                              logic [3:0] ck, logic gr, logic dl, logic bz, logic dn);
    vec_t v;
    v = '{st: st, sp: sp, dq: dq, g: g, ck: ck, gr: gr, dl: dl, bz: bz, dn: dn};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(string name, int row, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_all(string tag, int row, logic [3:0] ck, logic gr, logic dl,
                           logic bz, logic dn);
    check({tag, "_cken"}, row, cluster_cken, ck);
    check({tag, "_grst_l"}, row, {3'b0, cluster_grst_l}, {3'b0, gr});
    check({tag, "_dbginit_l"}, row, {3'b0, dbginit_l}, {3'b0, dl});
    check({tag, "_busy"}, row, {3'b0, busy}, {3'b0, bz});
    check({tag, "_done"}, row, {3'b0, done}, {3'b0, dn});
  endtask

  initial begin
    //   n  st sp dq gap  cken gr dl bz dn
    // power-up, gap=2: bits at k, k+3, k+6, k+9, release at k+17
    add(1, 1, 0, 0, 2, 4'h1, 0, 0, 1, 0);
    add(2, 0, 0, 0, 5, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 5, 4'h3, 0, 0, 1, 0);
    add(1, 1, 0, 0, 5, 4'h3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h7, 0, 0, 1, 0);
    add(2, 0, 0, 0, 0, 4'h7, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'hF, 0, 0, 1, 0);
    add(7, 0, 0, 0, 0, 4'hF, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'hF, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 4'hF, 1, 1, 0, 0);
    // debug-init pulse: low for 8 cycles
    add(1, 0, 0, 1, 0, 4'hF, 1, 0, 1, 0);
    add(7, 0, 0, 0, 0, 4'hF, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'hF, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 4'hF, 1, 1, 0, 0);
    // stop in RUN, gap=0
    add(1, 0, 1, 0, 0, 4'h7, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 5, 4'h0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 5, 4'h0, 0, 0, 0, 0);
    // stop in ENABLE after 0011, gap=1
    add(1, 1, 0, 0, 1, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h3, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 5, 4'h0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 5, 4'h0, 0, 0, 0, 0);
    // power-up gap=0, then stop+dbg_req together
    add(1, 1, 0, 0, 0, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h7, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'hF, 0, 0, 1, 0);
    add(7, 0, 0, 0, 0, 4'hF, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'hF, 1, 1, 0, 1);
    add(1, 0, 1, 1, 0, 4'h7, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h3, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    #1 arst_l = 1'b0;
    #2 check_all("reset", -1, 4'h0, 0, 0, 0, 0);
    repeat (2) @(negedge rclk);
    arst_l = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      start = vecs[r].st; stop = vecs[r].sp; dbg_req = vecs[r].dq; gap = vecs[r].g;
      @(posedge rclk);
      #1 check_all("vec", r, vecs[r].ck, vecs[r].gr, vecs[r].dl, vecs[r].bz, vecs[r].dn);
      @(negedge rclk);
    end
    start = 0; stop = 0; dbg_req = 0;

    // async reset mid-ENABLE
    start = 1; gap = 4'd3;
    @(posedge rclk);
    #1 start = 0;
    repeat (4) @(posedge rclk);
    #1 check_all("pre_arst", 0, 4'h3, 0, 0, 1, 0);
    #2 arst_l = 1'b0;
    #1 check_all("arst", 0, 4'h0, 0, 0, 0, 0);
    @(negedge rclk);
    arst_l = 1'b1;
    @(posedge rclk);
    #1 check_all("post_arst", 0, 4'h0, 0, 0, 0, 0);

    // scan override in IDLE
    @(negedge rclk);
    se = 1'b1;
    #1;
`ifdef CCX_CKEN_SCAN_OVR_EN
    check("scan_on_cken", 0, cluster_cken, 4'hF);
`else
    check("scan_on_cken", 0, cluster_cken, 4'h0);
`endif
    @(posedge rclk);
    #1 check("scan_busy", 0, {3'b0, busy}, 4'h0);
    se = 1'b0;
    #1 check("scan_off_cken", 0, cluster_cken, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccx_cken_seq.md
# ccx_cken_seq

Sequencer for a row of cluster clock headers. It staggers the per-cluster `cluster_cken` enables to limit di/dt, then releases cluster reset and debug-init after a settle interval. It also sequences debug-init pulses and the ordered power-down. It sits between the clock/reset control unit and the `cluster_cken`, `grst_l` and `gdbginit_l` inputs of the cluster headers in the CCX/CMP clock tree.

## Interface
Parameters:
- `NCLUST`, 4, number of cluster headers controlled (≥2)
- `GAP_W`, 4, width of the stagger-gap input
- `SETTLE`, 8, cycles between the last enable and reset release; also the debug-init pulse length (≥1)

Ports:
- `rclk` in 1: block clock, all state on the rising edge
- `arst_l` in 1: reset, asynchronous assert, active-low
- `start` in 1: single-cycle request to begin power-up
- `stop` in 1: single-cycle request to begin power-down
- `dbg_req` in 1: single-cycle request for a debug-init pulse
- `gap` in GAP_W: idle cycles between consecutive enable or disable steps
- `se` in 1: scan enable
- `cluster_cken` out NCLUST: per-cluster clock enables, bit i drives header i
- `cluster_grst_l` out 1: cluster reset, active-low
- `dbginit_l` out 1: cluster debug-init, active-low
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle pulse when a sequence completes

## Operation
- All outputs are registered.
- Reset values: `cluster_cken`=0, `cluster_grst_l`=0, `dbginit_l`=0, `busy`=0, `done`=0, state=IDLE.
- State machine states: IDLE, ENABLE, SETTLE, RUN, DBG, DISABLE.
- IDLE:
  - `start` latches `gap` into `gap_q`, sets `cluster_cken[0]` and goes to ENABLE with idx=0 and cnt=`gap_q`.
  - `stop` and `dbg_req` are ignored.
- ENABLE:
  - When cnt=0: set `cluster_cken[idx+1]`, increment idx, reload cnt=`gap_q`. Otherwise decrement cnt.
  - The edge that sets bit NCLUST-1 moves to SETTLE with cnt=SETTLE-1.
- SETTLE:
  - Decrement cnt. When cnt=0: set `cluster_grst_l`=1 and `dbginit_l`=1, pulse `done`, go to RUN.
- RUN:
  - `dbg_req` drives `dbginit_l`=0 and goes to DBG with cnt=SETTLE-1.
  - `stop` starts DISABLE.
- DBG:
  - Decrement cnt. When cnt=0: set `dbginit_l`=1, pulse `done`, return to RUN.
- DISABLE entry, on the same edge:
  - `cluster_grst_l`=0 and `dbginit_l`=0.
  - Latch `gap` into `gap_q`.
  - idx = index of the highest set `cluster_cken` bit; clear that bit; cnt=`gap_q`.
- DISABLE:
  - When cnt=0: clear bit idx-1, decrement idx, reload cnt. Otherwise decrement cnt.
  - The edge that clears bit 0 pulses `done` and goes to IDLE.
- Cken ordering: enables always go in ascending index, disables in descending index. `cluster_cken` is always a contiguous run of ones starting at bit 0.
- `busy` = 1 in ENABLE, SETTLE, DBG and DISABLE; 0 in IDLE and RUN.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `stop` in ENABLE, SETTLE or DBG aborts to DISABLE, starting from the current highest enabled bit.
  - `stop` in IDLE or DISABLE is ignored.
  - `stop` and `dbg_req` together in RUN: `stop` wins.
  - `dbg_req` outside RUN is ignored.
  - `gap` changes mid-sequence have no effect.
  - `gap`=0 gives steps on consecutive cycles.
  - Asserting `arst_l` low mid-sequence immediately forces all reset values, including `cluster_cken`=0 with no ordering.

## Timing
- Let `start` be sampled at edge k.
- `cluster_cken[i]` rises at edge k + i·(`gap`+1).
- `cluster_grst_l` and `dbginit_l` rise at edge k + (NCLUST-1)·(`gap`+1) + SETTLE. `done` is high for the cycle after that edge.
- DBG: `dbginit_l` is low for exactly SETTLE cycles.
- `stop` sampled at edge s in RUN:
  - `cluster_grst_l` falls at s.
  - Bit NCLUST-1-j clears at s + j·(`gap`+1).
  - `done` follows the edge that clears bit 0.
- Counters: idx is clog2(NCLUST) bits. cnt is max(GAP_W, clog2(SETTLE)) bits. No wrap occurs.

## Configuration
- `CCX_CKEN_SCAN_OVR_EN`
  - Defined: while `se`=1, `cluster_cken` output is forced to all ones combinationally after the register. The FSM and its internal cken register are unaffected.
  - Undefined: `se` is unused and `cluster_cken` is the register value only.

## Test plan
- Reset, then `start` with `gap`=2, NCLUST=4, SETTLE=8:
  - `cluster_cken` goes 0001, 0011, 0111, 1111 at edges k, k+3, k+6, k+9.
  - `cluster_grst_l`/`dbginit_l` rise at k+17; `done` pulses once.
- In RUN, `dbg_req`: `dbginit_l` is low for 8 cycles, `cluster_grst_l` stays 1, `done` pulses at the end.
- In RUN, `stop` with `gap`=0:
  - Reset outputs fall at the same edge.
  - cken goes 0111, 0011, 0001, 0000 on consecutive edges; then IDLE, `done` pulses.
- `stop` in ENABLE after cken=0011: the next edge gives 0001, `gap`+1 later 0000, then IDLE; `cluster_grst_l` never rose.
- Simultaneous `stop`+`dbg_req` in RUN enters DISABLE. `arst_l` pulsed low mid-ENABLE clears all outputs asynchronously.
- With `CCX_CKEN_SCAN_OVR_EN` defined, `se`=1 in IDLE gives `cluster_cken`=1111; dropping `se` returns it to 0000.
